// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback arbiter.
package wb_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NSRC_DEF  = 3;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned REG_W_DEF = 5;

  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_FPU  = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]  data;
  } wb_fifo_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending FPU writeback results with a parallel kill port.
// A kill clears the valid bit of every stored entry whose rd matches, and of
// the entry being pushed in the same cycle; killed entries still occupy a slot
// until they are popped.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [REG_W-1:0]           push_rd_i,
  input  logic [XLEN-1:0]            push_data_i,
  input  logic                       pop_i,
  input  logic                       kill_en_i,
  input  logic [REG_W-1:0]           kill_rd_i,
  output logic                       head_valid_o,
  output logic [REG_W-1:0]           head_rd_o,
  output logic [XLEN-1:0]            head_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  // Same layout as wb_fifo_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } entry_t;

  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_valid_o = entry_q[rd_ptr_q].valid;
  assign head_rd_o    = entry_q[rd_ptr_q].rd;
  assign head_data_o  = entry_q[rd_ptr_q].data;

  // Next storage contents: apply kill to stored entries, then write the push.
  // Push never targets a live slot because the producer is held off when full.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (kill_en_i && (entry_q[i].rd == kill_rd_i)) begin
        entry_d[i].valid = 1'b0;
      end
    end
    if (push_i) begin
      entry_d[wr_ptr_q].valid = !(kill_en_i && (push_rd_i == kill_rd_i));
      entry_d[wr_ptr_q].rd    = push_rd_i;
      entry_d[wr_ptr_q].data  = push_data_i;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards everything buffered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the pipeline's writeback with buffered FPU results
// onto one register-file write port. Pipeline always wins; FPU results drain
// into idle slots and are killed by a younger pipeline write to the same rd.
// Optional macro WB_FPU_BYPASS_EN: an FPU result arriving on an idle slot with
// an empty buffer is written directly, skipping the FIFO.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NSRC  = NSRC_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NSRC*XLEN-1:0]       src_data_i,
  input  logic [$clog2(NSRC)-1:0]    src_sel_i,
  input  logic                       pipe_we_i,
  input  logic [REG_W-1:0]           pipe_rd_i,
  input  logic                       fpu_valid_i,
  output logic                       fpu_ready_o,
  input  logic [XLEN-1:0]            fpu_data_i,
  input  logic [REG_W-1:0]           fpu_rd_i,
  output logic                       wb_we_o,
  output logic [REG_W-1:0]           wb_rd_o,
  output logic [XLEN-1:0]            wb_data_o,
  output logic                       wb_src_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int unsigned SEL_W = $clog2(NSRC);

  logic [XLEN-1:0]  pipe_data;
  logic             fpu_accept;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_valid;
  logic [REG_W-1:0] head_rd;
  logic [XLEN-1:0]  head_data;

  logic             wb_we_q, wb_we_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  wb_src_e          wb_src_q, wb_src_d;

  // Pipeline source mux; out-of-range selects read as zero.
  always_comb begin
    pipe_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_sel_i == SEL_W'(k)) begin
        pipe_data = src_data_i[k*XLEN +: XLEN];
      end
    end
  end

  assign fpu_ready_o = !fifo_full;
  assign fpu_accept  = fpu_valid_i && fpu_ready_o;
`ifdef WB_FPU_BYPASS_EN
  assign bypass      = fpu_accept && !pipe_we_i && fifo_empty;
`else
  assign bypass      = 1'b0;
`endif
  assign fifo_push   = fpu_accept && !bypass;
  assign fifo_pop    = !pipe_we_i && !fifo_empty;

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .REG_W (REG_W)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (fifo_push),
    .push_rd_i    (fpu_rd_i),
    .push_data_i  (fpu_data_i),
    .pop_i        (fifo_pop),
    .kill_en_i    (pipe_we_i),
    .kill_rd_i    (pipe_rd_i),
    .head_valid_o (head_valid),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .count_o      (fifo_count_o),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Priority select: pipeline > bypassed FPU > FIFO head; writes to x0 are dropped.
  always_comb begin
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_src_d  = wb_src_q;
    if (pipe_we_i) begin
      wb_we_d   = (pipe_rd_i != '0);
      wb_rd_d   = pipe_rd_i;
      wb_data_d = pipe_data;
      wb_src_d  = WB_SRC_PIPE;
    end else if (bypass) begin
      wb_we_d   = (fpu_rd_i != '0);
      wb_rd_d   = fpu_rd_i;
      wb_data_d = fpu_data_i;
      wb_src_d  = WB_SRC_FPU;
    end else if (fifo_pop) begin
      wb_we_d   = head_valid && (head_rd != '0);
      wb_rd_d   = head_rd;
      wb_data_d = head_data;
      wb_src_d  = WB_SRC_FPU;
    end
  end

  // Registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_src_q  <= WB_SRC_PIPE;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_src_q  <= wb_src_d;
    end
  end

  assign wb_we_o   = wb_we_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;
  assign wb_src_o  = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int XLEN  = 32;
  localparam int NSRC  = 3;
  localparam int DEPTH = 4;
  localparam int REG_W = 5;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic [NSRC*XLEN-1:0]       src_data_i = '0;
  logic [$clog2(NSRC)-1:0]    src_sel_i = '0;
  logic                       pipe_we_i = 1'b0;
  logic [REG_W-1:0]           pipe_rd_i = '0;
  logic                       fpu_valid_i = 1'b0;
  logic                       fpu_ready_o;
  logic [XLEN-1:0]            fpu_data_i = '0;
  logic [REG_W-1:0]           fpu_rd_i = '0;
  logic                       wb_we_o;
  logic [REG_W-1:0]           wb_rd_o;
  logic [XLEN-1:0]            wb_data_o;
  logic                       wb_src_o;
  logic [$clog2(DEPTH+1)-1:0] fifo_count_o;

  int n_chk = 0;
  int n_err = 0;
  logic [XLEN-1:0] rf12 = '0;
  int idx;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .src_data_i   (src_data_i),
    .src_sel_i    (src_sel_i),
    .pipe_we_i    (pipe_we_i),
    .pipe_rd_i    (pipe_rd_i),
    .fpu_valid_i  (fpu_valid_i),
    .fpu_ready_o  (fpu_ready_o),
    .fpu_data_i   (fpu_data_i),
    .fpu_rd_i     (fpu_rd_i),
    .wb_we_o      (wb_we_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .wb_src_o     (wb_src_o),
    .fifo_count_o (fifo_count_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [REG_W-1:0] rd,
                        input logic [XLEN-1:0] data, input logic src);
    chk({tag, "_we"},   wb_we_o,   1'b1);
    chk({tag, "_rd"},   wb_rd_o,   rd);
    chk({tag, "_data"}, wb_data_o, data);
    chk({tag, "_src"},  wb_src_o,  src);
  endtask

  // One clock; sample 1 time unit after the edge and update the rd=12 shadow register.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (wb_we_o && wb_rd_o == 5'd12) rf12 = wb_data_o;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},    wb_we_o,      1'b0);
    chk({tag, "_rd"},    wb_rd_o,      '0);
    chk({tag, "_data"},  wb_data_o,    '0);
    chk({tag, "_src"},   wb_src_o,     1'b0);
    chk({tag, "_count"}, fifo_count_o, '0);
    chk({tag, "_ready"}, fpu_ready_o,  1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    step(); step();
    chk_reset_state("rst");
    rst_ni = 1'b1;
    step();

    // Pipeline source mux and x0 suppression
    src_data_i = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
    pipe_we_i = 1'b1; src_sel_i = 2'd1; pipe_rd_i = 5'd7;
    step();
    chk_wb("pipe_sel1", 5'd7, 32'hDEAD_BEEF, 1'b0);
    src_sel_i = 2'd3; pipe_rd_i = 5'd8;
    step();
    chk_wb("pipe_sel3", 5'd8, 32'h0, 1'b0);
    src_sel_i = 2'd2; pipe_rd_i = 5'd31;
    step();
    chk_wb("pipe_sel2", 5'd31, 32'h3333_3333, 1'b0);
    src_sel_i = 2'd0; pipe_rd_i = 5'd0;
    step();
    chk("x0_we", wb_we_o, 1'b0);
    chk("x0_data", wb_data_o, 32'h1111_1111);
    pipe_we_i = 1'b0;
    step();

    // Single FPU result on an idle pipe
    chk("fpu1_ready", fpu_ready_o, 1'b1);
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd10; fpu_data_i = 32'h3F80_0000;
    step();
    fpu_valid_i = 1'b0;
`ifdef WB_FPU_BYPASS_EN
    chk_wb("fpu1_byp", 5'd10, 32'h3F80_0000, 1'b1);
    chk("fpu1_byp_count", fifo_count_o, 0);
`else
    chk("fpu1_n1_we", wb_we_o, 1'b0);
    chk("fpu1_n1_count", fifo_count_o, 1);
    step();
    chk_wb("fpu1_n2", 5'd10, 32'h3F80_0000, 1'b1);
    chk("fpu1_n2_count", fifo_count_o, 0);
`endif
    step();

    // Starvation under sustained pipeline writes, then in-order drain
    pipe_we_i = 1'b1; pipe_rd_i = 5'd1; src_sel_i = 2'd0;
    fpu_valid_i = 1'b1; idx = 1;
    for (int c = 0; c < 6; c++) begin
      fpu_rd_i = REG_W'(10 + idx);
      fpu_data_i = 32'hF000_0000 + XLEN'(idx);
      chk("starve_ready", fpu_ready_o, (c < 4));
      step();
      if (c < 4) idx++;
    end
    chk("starve_count", fifo_count_o, 4);
    chk("starve_ready_end", fpu_ready_o, 1'b0);
    chk("starve_src", wb_src_o, 1'b0);
    pipe_we_i = 1'b0;
    step();
    chk_wb("drain1", 5'd11, 32'hF000_0001, 1'b1);
    chk("drain1_ready", fpu_ready_o, 1'b1);
    step();
    fpu_valid_i = 1'b0;
    chk_wb("drain2", 5'd12, 32'hF000_0002, 1'b1);
    chk("drain2_count", fifo_count_o, 3);
    step();
    chk_wb("drain3", 5'd13, 32'hF000_0003, 1'b1);
    step();
    chk_wb("drain4", 5'd14, 32'hF000_0004, 1'b1);
    step();
    chk_wb("drain5", 5'd15, 32'hF000_0005, 1'b1);
    chk("drain_count", fifo_count_o, 0);
    step();

    // Buffered result for rd=12 killed by a younger pipeline write
    pipe_we_i = 1'b1; pipe_rd_i = 5'd3; src_sel_i = 2'd0;
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd12; fpu_data_i = 32'hAAAA_0012;
    step();
    chk("kill_count1", fifo_count_o, 1);
    fpu_valid_i = 1'b0; pipe_rd_i = 5'd12; src_sel_i = 2'd1;
    step();
    chk_wb("kill_pipe", 5'd12, 32'hDEAD_BEEF, 1'b0);
    chk("kill_count2", fifo_count_o, 1);
    pipe_we_i = 1'b0;
    step();
    chk("kill_pop_we", wb_we_o, 1'b0);
    chk("kill_pop_src", wb_src_o, 1'b1);
    chk("kill_pop_count", fifo_count_o, 0);
    chk("kill_rf12", rf12, 32'hDEAD_BEEF);

    // Same-cycle pipeline write and FPU accept to rd=9
    pipe_we_i = 1'b1; pipe_rd_i = 5'd9; src_sel_i = 2'd0;
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd9; fpu_data_i = 32'hBBBB_0009;
    step();
    pipe_we_i = 1'b0; fpu_valid_i = 1'b0;
    chk_wb("same_pipe", 5'd9, 32'h1111_1111, 1'b0);
    chk("same_count", fifo_count_o, 1);
    step();
    chk("same_pop_we", wb_we_o, 1'b0);
    chk("same_pop_count", fifo_count_o, 0);
    step();
    chk("same_idle_we", wb_we_o, 1'b0);

    // Reset with three results buffered
    pipe_we_i = 1'b1; pipe_rd_i = 5'd1; fpu_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fpu_rd_i = REG_W'(20 + c);
      fpu_data_i = 32'hC000_0000 + XLEN'(c);
      step();
    end
    chk("prerst_count", fifo_count_o, 3);
    pipe_we_i = 1'b0; fpu_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk_reset_state("midrst");
    step();
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("postrst_we", wb_we_o, 1'b0);
      chk("postrst_count", fifo_count_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
